// File: rtl/test_multiplo_param_if.sv
// Producer/consumer bundle for test_multiplo_param: dav_/rfd handshake, operands and result.
interface test_multiplo_param_if #(
  parameter int XW = 8,
  parameter int YW = 4
);
  logic          dav_;
  logic          rfd;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          m;
  logic [XW-1:0] q;
  logic [YW-1:0] r;
  logic          ok;
  logic          err;

  modport master (output dav_, x, y, input rfd, m, q, r, ok, err);
  modport slave  (input dav_, x, y, output rfd, m, q, r, ok, err);
endinterface

// File: rtl/test_multiplo_param.sv
// Divisibility tester: sequential restoring division, one quotient bit per clock.
// Optional macro TEST_MULTIPLO_POW2_FAST_EN short-cuts power-of-two divisors.
module test_multiplo_param #(
  parameter int XW = 8,
  parameter int YW = 4
) (
  input  logic                  clock,
  input  logic                  reset_,
  test_multiplo_param_if.slave  bus
);
  localparam int CW = $clog2(XW + 1);

  typedef enum logic [1:0] {IDLE, CALC, PRESENT, WAIT} state_t;

  state_t        state;
  logic [XW-1:0] xs;
  logic [YW-1:0] ys;
  logic [YW-1:0] rem;
  logic [XW-1:0] quo;
  logic [CW-1:0] cnt;

  logic [YW:0]   rem_shift;
  logic          ge;
  logic [YW-1:0] rem_next;
  logic          y_zero;
  logic          y_pow2;
  logic [XW-1:0] fast_q;
  logic [YW-1:0] fast_r;

  // The shifted remainder needs YW+1 bits; after the conditional subtract it fits in YW again.
  always_comb begin
    rem_shift = {rem, xs[XW-1]};
    ge        = (rem_shift >= {1'b0, ys});
    rem_next  = rem_shift[YW-1:0];
    if (ge) rem_next = YW'(rem_shift - {1'b0, ys});
    y_zero    = (ys == '0);
  end

`ifdef TEST_MULTIPLO_POW2_FAST_EN
  function automatic int pow2_log(input logic [YW-1:0] v);
    int k;
    k = 0;
    for (int i = 0; i < YW; i++)
      if (v[i]) k = i;
    return k;
  endfunction

  always_comb begin
    y_pow2 = !y_zero && ((ys & (ys - YW'(1))) == '0);
    fast_q = xs >> pow2_log(ys);
    fast_r = xs[YW-1:0] & (ys - YW'(1));
  end
`else
  always_comb begin
    y_pow2 = 1'b0;
    fast_q = '0;
    fast_r = '0;
  end
`endif

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state   <= IDLE;
      bus.rfd <= 1'b1;
      bus.ok  <= 1'b0;
      bus.m   <= 1'b0;
      bus.err <= 1'b0;
      bus.q   <= '0;
      bus.r   <= '0;
      xs      <= '0;
      ys      <= '0;
      rem     <= '0;
      quo     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.dav_) begin
            xs      <= bus.x;
            ys      <= bus.y;
            rem     <= '0;
            quo     <= '0;
            cnt     <= CW'(XW);
            bus.rfd <= 1'b0;
            state   <= CALC;
          end
        end
        CALC: begin
          if (y_zero) begin
            bus.q   <= '1;
            bus.r   <= '0;
            bus.m   <= 1'b0;
            bus.err <= 1'b1;
            bus.ok  <= 1'b1;
            state   <= PRESENT;
          end else if (y_pow2) begin
            bus.q   <= fast_q;
            bus.r   <= fast_r;
            bus.m   <= (fast_r == '0);
            bus.err <= 1'b0;
            bus.ok  <= 1'b1;
            state   <= PRESENT;
          end else if (cnt != '0) begin
            rem <= rem_next;
            quo <= {quo[XW-2:0], ge};
            xs  <= {xs[XW-2:0], 1'b0};
            cnt <= cnt - CW'(1);
          end else begin
            bus.q   <= quo;
            bus.r   <= rem;
            bus.m   <= (rem == '0);
            bus.err <= 1'b0;
            bus.ok  <= 1'b1;
            state   <= PRESENT;
          end
        end
        PRESENT: begin
          bus.ok <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          // Hold off the producer until it has dropped its request.
          if (bus.dav_) begin
            bus.rfd <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
